// File: rtl/serial_alu_ctrl.sv
// serial_alu_ctrl: bit-serial ALU that runs one WIDTH-bit AND/OR/ADD/SLT op LSB-first, one bit per clock
module serial_alu_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             ainv,
    input  logic             binv,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             ovf,
    output logic             zero
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    logic [1:0]       state;
    logic [WIDTH-1:0] a_r, b_r, sh, sh_nxt, res_nxt;
    logic             ainv_r, binv_r, carry;
    logic [1:0]       op_r;
    logic [CW-1:0]    cnt;
    logic             ai, bi, sum, cout, slice, last, ovf_int, set;
    assign busy = state == RUN;
    assign done = state == DONE;
    // one slice step on the current bit, plus the MSB overflow/set correction
    always_comb begin
        ai      = a_r[cnt] ^ ainv_r;
        bi      = b_r[cnt] ^ binv_r;
        sum     = ai ^ bi ^ carry;
        cout    = (ai & bi) | (ai & carry) | (bi & carry);
        slice   = op_r == 2'd0 ? ai & bi : op_r == 2'd1 ? ai | bi : op_r == 2'd2 ? sum : 1'b0;
        last    = cnt == CW'(WIDTH - 1);
        ovf_int = carry ^ cout;
        set     = sum ^ ovf_int;
        sh_nxt  = sh;
        sh_nxt[cnt] = slice;
        res_nxt = op_r == 2'd3 ? {{(WIDTH-1){1'b0}}, set} : sh_nxt;
    end
    // IDLE/RUN/DONE sequencing, operand latching and result capture on the MSB edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_r    <= '0;
            b_r    <= '0;
            ainv_r <= 1'b0;
            binv_r <= 1'b0;
            op_r   <= 2'd0;
            cnt    <= '0;
            sh     <= '0;
            carry  <= 1'b0;
            result <= '0;
            ovf    <= 1'b0;
            zero   <= 1'b0;
        end else if (state == IDLE) begin
            if (start) begin
                a_r    <= a;
                b_r    <= b;
                ainv_r <= ainv;
                binv_r <= binv;
                op_r   <= op;
                cnt    <= '0;
                sh     <= '0;
                carry  <= binv;
                state  <= RUN;
            end
        end else if (state == RUN) begin
            sh    <= sh_nxt;
            carry <= cout;
            cnt   <= cnt + CW'(1);
            if (last) begin
                result <= res_nxt;
                ovf    <= op_r[1] & ovf_int;
                zero   <= res_nxt == '0;
                state  <= DONE;
            end
        end else begin
            state <= IDLE;
        end
    end
endmodule

// File: tb/tb_serial_alu_ctrl.sv
// tb_serial_alu_ctrl: scoreboard bench with an arithmetic reference model for serial_alu_ctrl
module tb_serial_alu_ctrl;
    logic       clk = 0, rst_n = 0, start = 0, ainv = 0, binv = 0;
    logic [1:0] op = 0;
    logic [7:0] a = 0, b = 0;
    logic       busy, done, ovf, zero;
    logic [7:0] result;
    int         tot = 0, bad = 0, cyc = 0, busy_cnt = 0;
    logic       prev_done = 0;

    typedef struct {
        logic [7:0] r;
        logic       o;
        logic       z;
        int         acc;
    } exp_t;
    exp_t q[$];

    serial_alu_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ainv(ainv), .binv(binv),
        .op(op), .a(a), .b(b), .busy(busy), .done(done),
        .result(result), .ovf(ovf), .zero(zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        tot++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    // reference: whole-word arithmetic on the (optionally inverted) operands
    function automatic exp_t model(input logic [7:0] av, input logic [7:0] bv,
                                   input logic ai, input logic bi, input logic [1:0] o);
        logic [7:0] x, y;
        int         s;
        exp_t       e;
        x = ai ? ~av : av;
        y = bi ? ~bv : bv;
        s = int'($signed(x)) + int'($signed(y)) + (bi ? 1 : 0);
        e.o = (o >= 2'd2) && (s > 127 || s < -128);
        e.r = o == 2'd0 ? (x & y) : o == 2'd1 ? (x | y) : o == 2'd2 ? 8'(s) : {7'b0, s < 0};
        e.z = e.r == 8'h00;
        e.acc = 0;
        return e;
    endfunction

    // monitor: pops the scoreboard whenever done is presented
    always @(negedge clk) begin
        if (!rst_n) busy_cnt = 0;
        else if (busy) busy_cnt++;
        if (prev_done) chk("done_one_cycle", {31'b0, done}, 0);
        if (rst_n && done) begin
            chk("busy_and_done", {31'b0, busy}, 0);
            if (q.size() == 0) begin
                tot++;
                bad++;
                $display("FAIL unexpected_done: got done=1 expected no pending op");
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("result", {24'b0, result}, {24'b0, e.r});
                chk("ovf", {31'b0, ovf}, {31'b0, e.o});
                chk("zero", {31'b0, zero}, {31'b0, e.z});
                chk("latency", cyc - e.acc, 8);
                chk("busy_cycles", busy_cnt, 8);
            end
            busy_cnt = 0;
        end
        prev_done = done;
    end

    task automatic issue(input logic [7:0] av, input logic [7:0] bv,
                         input logic ai, input logic bi, input logic [1:0] o);
        exp_t e;
        bit   seen;
        a = av; b = bv; ainv = ai; binv = bi; op = o; start = 1;
        @(posedge clk); #1;
        e = model(av, bv, ai, bi, o);
        e.acc = cyc;
        q.push_back(e);
        start = 0;
        a = 8'($urandom); b = 8'($urandom); ainv = 1'($urandom); binv = 1'($urandom); op = 2'($urandom);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = done;
        end
        if (!seen) begin
            tot++;
            bad++;
            $display("FAIL done_timeout: got no done expected done within 20 cycles");
        end
        repeat (3) @(posedge clk);
        #1;
        chk("result_held", {24'b0, result}, {24'b0, e.r});
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_done", {31'b0, done}, 0);
        chk("rst_result", {24'b0, result}, 0);
        chk("rst_ovf", {31'b0, ovf}, 0);
        chk("rst_zero", {31'b0, zero}, 0);
        rst_n = 1;
        @(posedge clk); #1;
        issue(8'h7F, 8'h01, 0, 0, 2'd2);
        issue(8'h05, 8'h07, 0, 1, 2'd2);
        issue(8'h33, 8'h33, 0, 1, 2'd2);
        issue(8'h80, 8'h01, 0, 1, 2'd3);
        issue(8'h7F, 8'h80, 0, 1, 2'd3);
        issue(8'hF0, 8'h3C, 0, 0, 2'd0);
        issue(8'hF0, 8'h3C, 0, 0, 2'd1);
        issue(8'hF0, 8'h0F, 1, 1, 2'd0);
        issue(8'h00, 8'h00, 0, 0, 2'd0);
        issue(8'hFF, 8'hFF, 0, 0, 2'd2);
        // start held high: a new op is accepted only every 10 cycles
        start = 1;
        for (int i = 0; i < 40; i++) begin
            exp_t e;
            logic [7:0] av, bv;
            logic       ai, bi;
            logic [1:0] o;
            av = 8'($urandom); bv = 8'($urandom); ai = 1'($urandom); bi = 1'($urandom); o = 2'($urandom);
            a = av; b = bv; ainv = ai; binv = bi; op = o;
            @(posedge clk); #1;
            if (i % 10 == 0) begin
                e = model(av, bv, ai, bi, o);
                e.acc = cyc;
                q.push_back(e);
            end
        end
        start = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("handshake_drained", q.size(), 0);
        // reset abandoned mid-operation while counter is at bit 3
        a = 8'hFF; b = 8'h01; ainv = 0; binv = 1; op = 2'd2; start = 1;
        @(posedge clk); #1;
        start = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 0;
        @(posedge clk); #1;
        chk("midrst_busy", {31'b0, busy}, 0);
        chk("midrst_done", {31'b0, done}, 0);
        chk("midrst_result", {24'b0, result}, 0);
        chk("midrst_ovf", {31'b0, ovf}, 0);
        chk("midrst_zero", {31'b0, zero}, 0);
        rst_n = 1;
        @(posedge clk); #1;
        issue(8'h12, 8'h34, 0, 0, 2'd2);
        for (int i = 0; i < 60; i++)
            issue(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 2'($urandom));
        repeat (2) @(posedge clk);
        #1;
        chk("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end
endmodule
